// File: rtl/spi_frame_buffer_pkg.sv
// Shared state encoding and length helper for the SPI frame capture/replay buffer.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PRIME = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A frame length of zero or anything past the array size means "use the whole array".
  function automatic int unsigned clampLen(input int unsigned len, input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/spi_frame_buffer_if.sv
// Word-level handshake between the SPI receiver, the frame buffer and the SPI transmitter.
interface spi_frame_buffer_if #(
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport master (
    output rx_valid, rx_data, tx_req,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_valid, rx_data, tx_req,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/spi_frame_mem.sv
// Simple dual-port word array: synchronous write, registered read with enable.
module spi_frame_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  input  logic              rclr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is cleared; the array keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_frame_buffer.sv
// Captures one frame of frame_len SPI words, then replays it word by word to the transmitter.
module spi_frame_buffer
  import spi_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int LEN_W  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [LEN_W-1:0] frame_len,
  spi_frame_buffer_if.slave bus,
  output logic             frame_full,
  output logic             frame_sent,
  output logic             overflow,
  output logic             underflow,
  output logic [1:0]       state
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t            stateQ, stateD;
  logic [PTR_W-1:0]  wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [LEN_W-1:0]  lenQ, lenD, lenIn, lenEff, lastIdx;
  logic              loadLenQ;
  logic              txValidQ, txValidD, fullQ, fullD, sentQ, sentD;
  logic              ovfQ, ovfD, udfQ, udfD;
  logic              memWe, memRe, rdClr;
  logic [PTR_W-1:0]  memRaddr;

  assign lenIn   = LEN_W'(clampLen(32'(frame_len), DEPTH));
  // First cycle after reset release uses the freshly sampled length directly.
  assign lenEff  = loadLenQ ? lenIn : lenQ;
  assign lastIdx = lenEff - LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= ST_FILL;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD   = stateQ;
    wrPtrD   = wrPtrQ;
    rdPtrD   = rdPtrQ;
    lenD     = loadLenQ ? lenIn : lenQ;
    txValidD = txValidQ;
    fullD    = 1'b0;
    sentD    = 1'b0;
    ovfD     = ovfQ;
    udfD     = udfQ;
    memWe    = 1'b0;
    memRe    = 1'b0;
    memRaddr = rdPtrQ + PTR_W'(1);
    rdClr    = 1'b0;
    if (clear) begin
      stateD   = ST_FILL;
      wrPtrD   = '0;
      rdPtrD   = '0;
      lenD     = lenIn;
      txValidD = 1'b0;
      ovfD     = 1'b0;
      udfD     = 1'b0;
      rdClr    = 1'b1;
    end else begin
      case (stateQ)
        ST_FILL: begin
          if (bus.tx_req) udfD = 1'b1;
          if (bus.rx_valid) begin
            memWe = 1'b1;
            if (LEN_W'(wrPtrQ) == lastIdx) begin
              wrPtrD = '0;
              fullD  = 1'b1;
              stateD = ST_PRIME;
            end else begin
              wrPtrD = wrPtrQ + PTR_W'(1);
            end
          end
        end
        ST_PRIME: begin
          if (bus.tx_req)   udfD = 1'b1;
          if (bus.rx_valid) ovfD = 1'b1;
          memRe    = 1'b1;
          memRaddr = '0;
          txValidD = 1'b1;
          rdPtrD   = '0;
          stateD   = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.rx_valid) ovfD = 1'b1;
          if (bus.tx_req) begin
            if (LEN_W'(rdPtrQ) == lastIdx) begin
              txValidD = 1'b0;
              sentD    = 1'b1;
              rdPtrD   = '0;
              lenD     = lenIn;
              stateD   = ST_FILL;
            end else begin
              rdPtrD = rdPtrQ + PTR_W'(1);
              memRe  = 1'b1;
            end
          end
        end
        default: stateD = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ   <= '0;
      rdPtrQ   <= '0;
      lenQ     <= LEN_W'(DEPTH);
      loadLenQ <= 1'b1;
      txValidQ <= 1'b0;
      fullQ    <= 1'b0;
      sentQ    <= 1'b0;
      ovfQ     <= 1'b0;
      udfQ     <= 1'b0;
    end else begin
      wrPtrQ   <= wrPtrD;
      rdPtrQ   <= rdPtrD;
      lenQ     <= lenD;
      loadLenQ <= 1'b0;
      txValidQ <= txValidD;
      fullQ    <= fullD;
      sentQ    <= sentD;
      ovfQ     <= ovfD;
      udfQ     <= udfD;
    end
  end

  spi_frame_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uMem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (memWe),
    .waddr (wrPtrQ),
    .wdata (bus.rx_data),
    .re    (memRe),
    .raddr (memRaddr),
    .rclr  (rdClr),
    .rdata (bus.tx_data)
  );

  assign bus.tx_valid = txValidQ;
  assign frame_full   = fullQ;
  assign frame_sent   = sentQ;
  assign overflow     = ovfQ;
  assign underflow    = udfQ;
  assign state        = stateQ;

endmodule

// File: doc/spi_frame_buffer.md
Name: spi_frame_buffer

Overview:
- Parametrised successor to the fixed 64-byte SPI capture/replay block.
- Sits between the SPI word receiver and the SPI transmitter. Collects one frame of `frame_len` words, then presents them in order to the transmitter one word per request, then re-arms for the next frame.
- Adds the following over the fixed block: run-time frame length, registered read path, soft clear, overflow/underflow flags, and completion pulses.

Parameters:
- DATA_W, 8: width of one SPI word.
- DEPTH, 64: maximum words per frame; must be at least 2.
- LEN_W, $clog2(DEPTH+1): width of `frame_len`.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous soft clear; returns to FILL.
- frame_len  input  LEN_W  words per frame; sampled on entry to FILL.
- rx_valid  input  1  one-cycle pulse: `rx_data` holds a received word.
- rx_data  input  DATA_W  received word.
- tx_req  input  1  one-cycle pulse: transmitter consumed `tx_data` and wants the next word.
- tx_data  output  DATA_W  word to transmit; registered.
- tx_valid  output  1  `tx_data` is valid (DRAIN state).
- frame_full  output  1  one-cycle pulse: last word of the frame written.
- frame_sent  output  1  one-cycle pulse: last word of the frame consumed.
- overflow  output  1  sticky: `rx_valid` arrived outside FILL.
- underflow  output  1  sticky: `tx_req` arrived while `tx_valid`=0.
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset (rst_n=0, asynchronous) and its values:
  - state=FILL, wr_ptr=0, rd_ptr=0.
  - tx_data=0, tx_valid=0, frame_full=0, frame_sent=0, overflow=0, underflow=0.
  - len_q = DEPTH.
  - Memory contents are not reset.
- Length latch:
  - len_q <= `frame_len` on reset release, on `clear`, and on every DRAIN->FILL transition.
  - A value of 0 or greater than DEPTH is treated as DEPTH.
- State encoding: FILL=0, PRIME=1, DRAIN=2.
- FILL:
  - On `rx_valid`: mem[wr_ptr] <= `rx_data`, then wr_ptr++.
  - If wr_ptr == len_q-1 on that write: wr_ptr <= 0, `frame_full` pulses on the next cycle, next state is PRIME.
- PRIME (exactly one cycle):
  - tx_data <= mem[0], tx_valid <= 1, rd_ptr <= 0, next state is DRAIN.
  - Latency from the last `rx_valid` to tx_valid=1 is 2 cycles.
- DRAIN:
  - On `tx_req` with rd_ptr < len_q-1: rd_ptr++ and tx_data <= mem[rd_ptr+1]. The new word is visible the cycle after `tx_req`.
  - On `tx_req` with rd_ptr == len_q-1: tx_valid <= 0, `frame_sent` pulses, rd_ptr <= 0, len_q re-latched, next state is FILL.
  - `tx_data` holds its value until the next `tx_req`.
- Flags:
  - `rx_valid` in PRIME or DRAIN: the word is dropped and `overflow` <= 1.
  - `tx_req` in FILL or PRIME: ignored and `underflow` <= 1.
  - Both flags clear only on reset or `clear`.
- Simultaneous events:
  - `rx_valid` and `tx_req` in DRAIN: the `tx_req` is processed and `overflow` is set.
  - `clear` with any other input: `clear` wins. It applies reset values except `len_q`, which is re-sampled, and memory, which is untouched.
- Pointer widths: $clog2(DEPTH). Pointers never wrap past len_q-1.
- `frame_len` changes mid-frame have no effect until the next re-latch.

Decomposition:
- Package spi_frame_pkg holds:
  - state localparams ST_FILL, ST_PRIME, ST_DRAIN;
  - a helper function that clamps the length against DEPTH.
- Sub-module spi_frame_mem: a DEPTH x DATA_W simple dual-port register array, synchronous write, registered read with read enable. The top level holds the FSM, pointers and flags.

Test Plan:
1. Reset, frame_len=4, write 4 words A1,B2,C3,D4:
   - `frame_full` pulses once, 1 cycle after the D4 write;
   - tx_valid=1 with tx_data=A1 exactly 2 cycles after D4.
2. Apply 4 `tx_req` pulses, spaced 3 cycles apart:
   - tx_data sequence is B2, C3, D4;
   - on the 4th request, tx_valid drops and `frame_sent` pulses;
   - state returns to FILL with no flags set.
3. frame_len=0, DEPTH=64, write 64 words 0x00..0x3F:
   - `frame_full` fires only after word 0x3F;
   - the drain returns 0x00..0x3F in order.
4. Send `rx_valid` 0x55 in DRAIN, then a `tx_req` before any frame is loaded:
   - `overflow`=1 and `underflow`=1, both sticky;
   - the drained data is unchanged;
   - `clear` returns both flags to 0.
5. Assert rst_n=0 mid-FILL, after 2 of 4 words, then release:
   - all outputs are 0 immediately, without a clock edge;
   - the next 4 words form a full frame starting at index 0.
6. Change frame_len from 4 to 2 during the drain:
   - the current frame still drains 4 words;
   - the next frame fills after 2 words.
